step_pulse_gen: RTL and testbench
=================================

// Module: step_pulse_gen
// PURPOSE
//  Upstream stage of the 4-bit synchronous JK counter. Turns a raw mechanical
//  step button into clean single-cycle step pulses, or, in auto mode, makes a
//  periodic pulse. Drives the counter's toggle enable (J=K=step on the LSB).
//  Contains a 2-flop synchronizer, a debounce FSM and an auto-period timer.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive synced-high cycles needed to accept a press (>=2)
//  AUTO_PERIOD      8  cycles between auto-mode pulses (>=2)
// PORTS
//  clk       in   1  rising-edge clock
//  reset     in   1  asynchronous, active-low reset (0 = reset)
//  btn       in   1  raw asynchronous button, high = pressed
//  auto_mode in   1  synchronous; 1 = periodic pulses, 0 = button pulses
//  step      out  1  one-cycle pulse; feeds j and k of the counter LSB
//  btn_db    out  1  debounced button level (1 in PRESSED/RELEASE_WAIT)
//  state     out  2  FSM state: 0 IDLE, 1 PRESS_WAIT, 2 PRESSED, 3 RELEASE_WAIT
// BEHAVIOUR
//  - Reset (reset=0, async): sync flops=0, state=IDLE, debounce cnt=0,
//    period cnt=0, step=0, btn_db=0. Reset mid-press discards the press.
//  - Sync: s1<=btn, s2<=s1 each edge; FSM uses btn_s=s2 only.
//  - Counters are $clog2(param) bits wide and never exceed param-1.
//  - FSM, evaluated every edge:
//    IDLE:         btn_s=1 -> PRESS_WAIT, cnt<=0.
//    PRESS_WAIT:   btn_s=0 -> IDLE (bounce, no pulse).
//                  btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, press event.
//                  Otherwise cnt++.
//    PRESSED:      btn_s=0 -> RELEASE_WAIT, cnt<=0.
//    RELEASE_WAIT: btn_s=1 -> PRESSED (bounce, no new event).
//                  btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//                  Otherwise cnt++.
//  - Press latency: let E0 be the first edge that samples btn=1, with btn held
//    steady. Then step=1 during the cycle after edge E0+DEBOUNCE_CYCLES+2,
//    i.e. after the 7th edge for the default. step is a registered output.
//  - step is exactly one cycle wide per accepted press. Holding btn never
//    repeats the pulse. The next pulse needs IDLE to be reached first.
//  - auto_mode=1: button events are suppressed (FSM and btn_db keep running).
//    The period counter increments every edge. At AUTO_PERIOD-1 it wraps to 0
//    and step=1 the next cycle. The first pulse comes AUTO_PERIOD edges after
//    the edge that first samples auto_mode=1.
//  - auto_mode=0: the period counter is held at 0. step comes only from press
//    events.
//  - auto_mode changing on the same edge as a press event: the new mode takes
//    effect that edge. A 0->1 change drops the press event; a 1->0 change
//    issues it. step never exceeds one cycle per edge.
//  - btn held high across reset release: treated as a fresh press, giving one
//    pulse after normal latency.
// TESTING (defaults D=4, P=8)
//  1 reset=0 with btn=1, auto=0 -> step=0, btn_db=0, state=0; release reset
//    -> one step pulse after 7th edge.
//  2 clean press held 20 cycles -> exactly one step, 7 edges after E0; btn_db=1
//    until 4 synced-low cycles after release.
//  3 bounce: btn 1,0,1,0 on alternate cycles, then steady 1 -> no step during
//    bounce, one step after steady; release bounce -> no extra step.
//  4 auto=1 for 40 cycles -> step at edges 8,16,24,32,40 after auto sampled;
//    pressing btn meanwhile adds no pulses.
//  5 reset pulsed low mid-PRESS_WAIT (cnt=2) -> state=0 and no step at once;
//    press must restart the full 7-edge latency.
//  6 auto 1->0 on the press-event edge -> single one-cycle step; 0->1 on that
//    edge -> no step until the period expires.

Source files
------------

// File: rtl/step_pulse_gen.sv
// Step-pulse source for the 4-bit JK counter: synchronizes and debounces a raw
// button into single-cycle pulses, or generates periodic pulses in auto mode.
module step_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int AUTO_PERIOD     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   input  logic       auto_mode,
   output logic       step,
   output logic       btn_db,
   output logic [1:0] state
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int PER_W = $clog2(AUTO_PERIOD);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(AUTO_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

   logic             sync1_q;
   logic             sync2_q;
   logic             btn_s;
   state_t           state_q;
   state_t           state_d;
   logic [DB_W-1:0]  db_cnt_q;
   logic [DB_W-1:0]  db_cnt_d;
   logic [PER_W-1:0] per_cnt_q;
   logic [PER_W-1:0] per_cnt_d;
   logic             step_q;
   logic             step_d;
   logic             btn_db_q;
   logic             btn_db_d;
   logic             press_evt_s;

   assign btn_s = sync2_q;

   // Two-flop synchronizer for the asynchronous button input.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         db_cnt_q  <= '0;
         per_cnt_q <= '0;
         step_q    <= 1'b0;
         btn_db_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         db_cnt_q  <= db_cnt_d;
         per_cnt_q <= per_cnt_d;
         step_q    <= step_d;
         btn_db_q  <= btn_db_d;
      end
   end

   // Debounce next-state logic; a press event fires once on PRESS_WAIT -> PRESSED.
   always_comb begin
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      press_evt_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (btn_s) begin
               state_d  = ST_PRESS_WAIT;
               db_cnt_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = ST_IDLE;
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = ST_PRESSED;
               press_evt_s = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         ST_PRESSED: begin
            if (!btn_s) begin
               state_d  = ST_RELEASE_WAIT;
               db_cnt_d = '0;
            end else begin
               state_d = ST_PRESSED;
            end
         end
         ST_RELEASE_WAIT: begin
            if (btn_s) begin
               state_d = ST_PRESSED;
            end else if (db_cnt_q == DB_LAST) begin
               state_d = ST_IDLE;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         default: begin
            state_d  = ST_IDLE;
            db_cnt_d = '0;
         end
      endcase
   end

   // Output selection: auto mode masks press events and runs the period timer.
   always_comb begin
      per_cnt_d = '0;
      step_d    = 1'b0;
      if (auto_mode) begin
         if (per_cnt_q == PER_LAST) begin
            per_cnt_d = '0;
            step_d    = 1'b1;
         end else begin
            per_cnt_d = per_cnt_q + PER_W'(1);
            step_d    = 1'b0;
         end
      end else begin
         per_cnt_d = '0;
         step_d    = press_evt_s;
      end
      btn_db_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
   end

   assign step   = step_q;
   assign btn_db = btn_db_q;
   assign state  = state_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: a per-cycle vector table for press and
// bounce sequences, plus hand sequences for auto mode, reset and mode-change edges.
module tb_step_pulse_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn;
   logic       auto_mode;
   logic       step;
   logic       btn_db;
   logic [1:0] state;

   int n_chk  = 0;
   int n_fail = 0;

   step_pulse_gen #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn),
      .auto_mode (auto_mode),
      .step      (step),
      .btn_db    (btn_db),
      .state     (state)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       b;
      logic       a;
      logic       stp;
      logic       db;
      logic [1:0] st;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_n(input int n, input logic r, input logic b, input logic a,
                                 input logic s, input logic d, input logic [1:0] st);
      vec_t v;
      v.rst = r; v.b = b; v.a = a; v.stp = s; v.db = d; v.st = st;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic b, input logic a, input logic exp_s, input string nm);
      btn       = b;
      auto_mode = a;
      tick();
      chk(nm, int'(step), int'(exp_s));
   endtask

   initial begin
      reset     = 1'b0;
      btn       = 1'b0;
      auto_mode = 1'b0;

      // Reset with button held, release: fresh press, step after 7th edge; hold then release.
      add_n(2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      add_n(2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      add_n(4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      add_n(1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2);
      add_n(13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
      add_n(2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      add_n(4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      add_n(3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      // Press bounce 1,0,1,0 then steady high.
      add_n(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      add_n(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      add_n(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      add_n(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      add_n(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      add_n(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      add_n(4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
      add_n(1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2);
      add_n(2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
      // Release bounce 0,1,0,1 then steady low.
      add_n(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      add_n(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
      add_n(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      add_n(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
      add_n(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      add_n(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      add_n(4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      add_n(2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         reset     = vecs[i].rst;
         btn       = vecs[i].b;
         auto_mode = vecs[i].a;
         tick();
         chk($sformatf("vec%0d step", i),   int'(step),   int'(vecs[i].stp));
         chk($sformatf("vec%0d btn_db", i), int'(btn_db), int'(vecs[i].db));
         chk($sformatf("vec%0d state", i),  int'(state),  int'(vecs[i].st));
      end

      // Auto mode for 40 edges with a press in the middle: pulses only every 8th edge.
      for (int i = 1; i <= 40; i++) begin
         cyc((i >= 5 && i <= 25), 1'b1, (i % 8 == 0), $sformatf("auto edge%0d step", i));
         if (i == 12) begin
            chk("auto fsm pressed", int'(state), 2);
            chk("auto btn_db", int'(btn_db), 1);
         end
         if (i == 40) chk("auto fsm idle", int'(state), 0);
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, $sformatf("auto off%0d step", i));

      // Reset mid PRESS_WAIT (cnt=2), then full latency restarts.
      for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 1'b0, $sformatf("rst pre%0d step", i));
      chk("rst pre state", int'(state), 1);
      reset = 1'b0;
      #1;
      chk("rst async state", int'(state), 0);
      chk("rst async step", int'(step), 0);
      chk("rst async btn_db", int'(btn_db), 0);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k <= 7; k++) cyc(1'b1, 1'b0, (k == 6), $sformatf("rst post%0d step", k));
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b0, $sformatf("rst rel%0d step", k));
      chk("rst rel state", int'(state), 0);

      // auto 1->0 on the press-event edge issues the press pulse.
      for (int k = 0; k <= 8; k++) cyc(1'b1, (k <= 5), (k == 6), $sformatf("m10 e%0d step", k));
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b0, $sformatf("m10 rel%0d step", k));
      chk("m10 idle state", int'(state), 0);

      // auto 0->1 on the press-event edge drops it; first auto pulse 8 edges later.
      for (int k = 0; k <= 14; k++) begin
         cyc(1'b1, (k >= 6), (k == 13), $sformatf("m01 e%0d step", k));
         if (k == 6) chk("m01 fsm pressed", int'(state), 2);
      end
      for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b0, $sformatf("m01 rel%0d step", k));
      chk("m01 idle state", int'(state), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
